spi_seq: RTL and testbench
==========================

Name: spi_seq

Overview:
- Transfer sequencer and arbiter in front of the SPI master's register bus ($0 status, $1 data, $2 prescaler, $3 chip-select).
- Up to NREQ on-chip requesters (CPU shim, SD boot loader, etc.) each post single-byte transfers with a target chip select.
- spi_seq arbitrates between them round-robin, selects the chip, writes TX, polls RDY, reads RX and returns it with a done pulse.
- Supports locked bursts, where CS stays asserted across bytes from one owner.

Parameters:
- NREQ, 2, number of requesters (1..4).
- LO_TIMEOUT, 64, max clk cycles to see RDY fall after the data write.
- HI_TIMEOUT, 65535, max clk cycles to see RDY rise once low (16-bit counter).

Ports:
- clk  in  1  system clock, same clock as the SPI master register bus.
- rst  in  1  synchronous reset, active-high.
- req  in  NREQ  per-requester transfer request; level, held until done.
- hold  in  NREQ  keep CS asserted and arbitration locked after this byte.
- cs_sel  in  3*NREQ  chip-select number per requester (slice i = bits 3i+2:3i).
- tx  in  8*NREQ  transmit byte per requester.
- gnt  out  NREQ  one-hot owner of the SPI master; 0 when idle.
- done  out  NREQ  one-cycle pulse to the owner when rx is valid or on error.
- rx  out  8  received byte, valid with done and held until the next done.
- err  out  1  sticky timeout flag; cleared when any new transfer is granted.
- busy  out  1  high in every state except IDLE.
- spi_ad  out  3  SPI master register address.
- spi_di  out  8  SPI master write data.
- spi_do  in  8  SPI master read data, registered: valid one clk after a read cycle.
- spi_rw  out  1  1 = read, 0 = write.
- spi_cs  out  1  SPI master bus select.

Behaviour:
- Reset: state IDLE; gnt=0, done=0, rx=8'hFF, err=0, busy=0, spi_cs=0, spi_rw=1, spi_ad=0, spi_di=0, rr pointer=NREQ-1.
- Reset in any state aborts at once. No deselect write is issued; the SPI master is reset by the same rst.
- IDLE: if any req, grant the first requester in order rr+1, rr+2, ... (mod NREQ).
  - Latch owner; set rr=owner; gnt one-hot; clear err.
  - Next state SEL. Decision takes 1 cycle.
- SEL (1 cycle): write $3 = {1,3'b000,1,cs_sel[owner]} (IUS=1, CSE=1). Next state WR.
- WR (1 cycle): write $1 = tx[owner]. This starts the shift. Next state WAITLO.
- WAITLO: read $0 every cycle.
  - spi_do[7] is examined only from the 2nd cycle in the state onward, because reads are registered.
  - spi_do[7]=0 → WAITHI.
  - Counter reaches LO_TIMEOUT → set err, go to DESEL with done pulse and rx unchanged.
- WAITHI: read $0 every cycle, same 2nd-cycle rule.
  - spi_do[7]=1 → RD.
  - Counter reaches HI_TIMEOUT → err, done, DESEL.
- RD (1 cycle): read $1. Next state CAP.
- CAP (1 cycle): rx<=spi_do; done[owner]=1; spi_cs=0.
  - hold[owner]=1 → LOCK.
  - Otherwise → DESEL.
- LOCK: spi_cs=0; gnt kept; other requesters are ignored.
  - req[owner]=1 → WR, using the new tx; no SEL is repeated.
  - hold[owner]=0 with no req → DESEL.
  - req and hold both high → WR takes priority.
- DESEL (1 cycle): write $3 = 8'h00. Then gnt=0, → IDLE.
- Requester changing tx or cs_sel after grant: ignored until its next WR/SEL; values are sampled in the write cycle.
- req dropped mid-transfer: the transfer still completes and done still pulses.
- Latency: an uncontended single byte takes 1 (arb) + 1 (SEL) + 1 (WR) + polls + 1 (RD) + 1 (CAP) cycles; done arrives ≥6 cycles after req.
- Outside the write and read cycles above, spi_cs=0 except during polling. The block never writes $0 or $2; prescaler setup stays with the CPU.
- When NREQ=1, arbitration is trivial and gnt[0] follows ownership.

Test Plan:
- Single transfer: req0, cs_sel0=3, tx0=8'hA5, behavioural SPI master looping MOSI→MISO, prescaler 0 → writes $3=8'h8B then $1=8'hA5; done0 pulses once, rx=8'hA5, $3=8'h00 written, gnt=0.
- Round-robin: req0 and req1 held continuously with hold=0 → grants alternate 0,1,0,1 across 4 transfers; each transfer is bracketed by its own SEL/DESEL.
- Burst: req1 with hold1=1 for 3 bytes 8'h01,8'h02,8'h03 while req0 is high → exactly one $3 select write and three $1 writes; req0 is not granted until after DESEL.
- Timeout: SPI model never drops RDY → after LO_TIMEOUT cycles err=1, done pulses, rx keeps its previous value, $3=8'h00 written; the next grant clears err.
- Reset mid-transfer: assert rst during WAITHI → next cycle gnt=0, busy=0, spi_cs=0, rx=8'hFF, err=0; a following request completes normally.
- Slow SPI: prescaler 8'hFF and a slow clk_in → no timeout; polling holds spi_ad=0, spi_rw=1 until RDY rises; rx is correct.

Source files
------------

// File: rtl/spi_seq.sv
// spi_seq: round-robin transfer sequencer driving an SPI master register bus
module spi_seq #(
  parameter int NREQ       = 2,
  parameter int LO_TIMEOUT = 64,
  parameter int HI_TIMEOUT = 65535
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ-1:0]   hold,
  input  logic [3*NREQ-1:0] cs_sel,
  input  logic [8*NREQ-1:0] tx,
  output logic [NREQ-1:0]   gnt,
  output logic [NREQ-1:0]   done,
  output logic [7:0]        rx,
  output logic              err,
  output logic              busy,
  output logic [2:0]        spi_ad,
  output logic [7:0]        spi_di,
  input  logic [7:0]        spi_do,
  output logic              spi_rw,
  output logic              spi_cs
);
  localparam int W = NREQ > 1 ? $clog2(NREQ) : 1;
  typedef enum logic [3:0] {IDLE, SEL, WR, WAITLO, WAITHI, RD, CAP, LOCK, DESEL} state_t;
  state_t state, state_n;
  logic [W-1:0] owner, rr, pick, idx;
  logic [15:0] cnt;
  logic [7:0] rx_q, tx_o;
  logic [2:0] cs_o;
  logic req_o, hold_o, timeout;
  always_comb begin
    pick = rr;
    idx = rr;
    for (int k = NREQ; k >= 1; k--) begin
      idx = W'((int'(rr) + k) % NREQ);
      if (req[idx]) pick = idx;
    end
  end
  always_comb begin
    cs_o = '0;
    tx_o = '0;
    req_o = 1'b0;
    hold_o = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (owner == W'(i)) begin
        cs_o = cs_sel[3*i +: 3];
        tx_o = tx[8*i +: 8];
        req_o = req[i];
        hold_o = hold[i];
      end
    end
  end
  // status reads are registered, so RDY is only trusted from the second poll cycle
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = |req ? SEL : IDLE;
      SEL:     state_n = WR;
      WR:      state_n = WAITLO;
      WAITLO:  state_n = (cnt != 16'd0 && !spi_do[7]) ? WAITHI :
                         (cnt == 16'(LO_TIMEOUT - 1)) ? DESEL : WAITLO;
      WAITHI:  state_n = (cnt != 16'd0 && spi_do[7]) ? RD :
                         (cnt == 16'(HI_TIMEOUT - 1)) ? DESEL : WAITHI;
      RD:      state_n = CAP;
      CAP:     state_n = hold_o ? LOCK : DESEL;
      LOCK:    state_n = req_o ? WR : hold_o ? LOCK : DESEL;
      DESEL:   state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  assign timeout = (state == WAITLO || state == WAITHI) && state_n == DESEL;
  always_ff @(posedge clk) state <= rst ? IDLE : state_n;
  always_ff @(posedge clk) begin
    if (rst) begin
      owner <= '0;
      rr <= W'(NREQ - 1);
      gnt <= '0;
      err <= 1'b0;
      rx_q <= 8'hFF;
      cnt <= 16'd0;
    end else begin
      cnt <= (state_n == state) ? cnt + 16'd1 : 16'd0;
      if (state == IDLE && state_n == SEL) begin
        owner <= pick;
        rr <= pick;
        gnt <= '0;
        gnt[pick] <= 1'b1;
        err <= 1'b0;
      end
      if (timeout) err <= 1'b1;
      if (state == CAP) rx_q <= spi_do;
      if (state == DESEL) gnt <= '0;
    end
  end
  // err is cleared at every grant, so in DESEL it marks a timeout of this transfer
  assign done = (state == CAP || (state == DESEL && err)) ? gnt : '0;
  assign rx = state == CAP ? spi_do : rx_q;
  assign busy = state != IDLE;
  assign spi_cs = state != IDLE && state != CAP && state != LOCK;
  assign spi_rw = !(state == SEL || state == WR || state == DESEL);
  assign spi_ad = (state == SEL || state == DESEL) ? 3'd3 : (state == WR || state == RD) ? 3'd1 : 3'd0;
  assign spi_di = state == SEL ? {4'b1000, 1'b1, cs_o} : state == WR ? tx_o : 8'h00;
endmodule

// File: tb/tb_spi_seq.sv
// tb_spi_seq: scoreboard bench for spi_seq against a behavioural SPI master model
module tb_spi_seq;
  logic clk = 1'b0, rst = 1'b1;
  logic [1:0] req = '0, hold = '0;
  logic [5:0] cs_sel = '0;
  logic [15:0] tx = '0;
  logic [1:0] gnt, done;
  logic [7:0] rx, spi_di, spi_do;
  logic err, busy, spi_rw, spi_cs;
  logic [2:0] spi_ad;

  spi_seq #(.NREQ(2), .LO_TIMEOUT(64), .HI_TIMEOUT(65535)) dut (
    .clk(clk), .rst(rst), .req(req), .hold(hold), .cs_sel(cs_sel), .tx(tx),
    .gnt(gnt), .done(done), .rx(rx), .err(err), .busy(busy),
    .spi_ad(spi_ad), .spi_di(spi_di), .spi_do(spi_do), .spi_rw(spi_rw), .spi_cs(spi_cs)
  );

  always #5 clk = ~clk;

  // SPI master model: RDY falls lo_delay cycles after a data write, rises busy_len later
  int lo_delay = 2, busy_len = 4, ph = 0, mc = 0;
  logic [7:0] xmask = 8'h00, sh, mdata;
  logic rdy;
  always @(posedge clk) begin
    if (rst) begin
      rdy <= 1'b1; ph <= 0; mc <= 0; spi_do <= 8'h00; mdata <= 8'h00; sh <= 8'h00;
    end else begin
      if (spi_cs && spi_rw)
        spi_do <= spi_ad == 3'd0 ? {rdy, 7'd0} : spi_ad == 3'd1 ? mdata : 8'h00;
      if (spi_cs && !spi_rw && spi_ad == 3'd1) begin
        ph <= 1; mc <= lo_delay; sh <= spi_di;
      end else if (ph == 1) begin
        if (mc == 0) begin rdy <= 1'b0; ph <= 2; mc <= busy_len; end
        else mc <= mc - 1;
      end else if (ph == 2) begin
        if (mc == 0) begin rdy <= 1'b1; ph <= 0; mdata <= sh ^ xmask; end
        else mc <= mc - 1;
      end
    end
  end

  typedef struct { logic [1:0] dn; logic [7:0] rxv; logic e; } dexp_t;
  typedef struct { logic [2:0] ad; logic [7:0] di; } wexp_t;
  dexp_t dq[$];
  wexp_t wq[$];
  dexp_t dm;
  wexp_t wm;
  int total = 0, bad = 0, poll_bad = 0, poll_cnt = 0, lat;

  task automatic chk(input string nm, input logic [15:0] a, input logic [15:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, a, e);
    end
  endtask

  task automatic ew(input logic [2:0] ad, input logic [7:0] di);
    wm.ad = ad; wm.di = di; wq.push_back(wm);
  endtask

  task automatic ed(input logic [1:0] dn, input logic [7:0] rxv, input logic e);
    dexp_t d;
    d.dn = dn; d.rxv = rxv; d.e = e; dq.push_back(d);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (|done) begin
        total++;
        if (dq.size() == 0) begin
          bad++;
          $display("FAIL done_unexpected: got done=%b with nothing expected", done);
        end else begin
          dm = dq.pop_front();
          chk("done_owner", 16'(done), 16'(dm.dn));
          chk("rx", 16'(rx), 16'(dm.rxv));
          chk("err_at_done", 16'(err), 16'(dm.e));
          chk("gnt_at_done", 16'(gnt), 16'(dm.dn));
        end
      end
      if (spi_cs && !spi_rw) begin
        if (wq.size() == 0) begin
          total++; bad++;
          $display("FAIL write_unexpected: got ad=%0d di=%0h with nothing expected", spi_ad, spi_di);
        end else begin
          wm = wq.pop_front();
          chk("write_ad", 16'(spi_ad), 16'(wm.ad));
          chk("write_di", 16'(spi_di), 16'(wm.di));
        end
      end
      if (ph == 2) begin
        poll_cnt++;
        if (!(spi_cs && spi_rw && spi_ad == 3'd0)) poll_bad++;
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wait_done(input int i, output int n);
    int k;
    for (k = 0; k < 3000; k++) begin
      tick();
      if (done[i]) break;
    end
    n = k + 1;
    chk("done_wait_bound", 16'(k < 3000), 16'd1);
  endtask

  task automatic wait_gnt(input int i);
    int k;
    for (k = 0; k < 100; k++) begin
      tick();
      if (gnt[i]) break;
    end
    chk("gnt_wait_bound", 16'(k < 100), 16'd1);
  endtask

  task automatic wait_idle();
    int k;
    for (k = 0; k < 100; k++) begin
      tick();
      if (!busy) break;
    end
    chk("idle_wait_bound", 16'(k < 100), 16'd1);
  endtask

  initial begin
    repeat (3) tick();
    chk("rst_gnt", 16'(gnt), 16'd0);
    chk("rst_done", 16'(done), 16'd0);
    chk("rst_rx", 16'(rx), 16'hFF);
    chk("rst_err", 16'(err), 16'd0);
    chk("rst_busy", 16'(busy), 16'd0);
    chk("rst_spi_cs", 16'(spi_cs), 16'd0);
    chk("rst_spi_rw", 16'(spi_rw), 16'd1);
    chk("rst_spi_ad", 16'(spi_ad), 16'd0);
    chk("rst_spi_di", 16'(spi_di), 16'd0);
    rst = 1'b0;
    // single transfer, loopback
    cs_sel[2:0] = 3'd3; tx[7:0] = 8'hA5;
    ew(3'd3, 8'h8B); ew(3'd1, 8'hA5); ew(3'd3, 8'h00); ed(2'b01, 8'hA5, 1'b0);
    req[0] = 1'b1;
    wait_done(0, lat);
    req[0] = 1'b0;
    chk("latency_ge6", 16'(lat >= 6), 16'd1);
    wait_idle();
    chk("single_gnt_idle", 16'(gnt), 16'd0);
    // round robin from a fresh pointer
    rst = 1'b1; tick(); rst = 1'b0;
    cs_sel = {3'd2, 3'd1}; tx = {8'hC3, 8'h5A};
    for (int n = 0; n < 2; n++) begin
      ew(3'd3, 8'h89); ew(3'd1, 8'h5A); ew(3'd3, 8'h00); ed(2'b01, 8'h5A, 1'b0);
      ew(3'd3, 8'h8A); ew(3'd1, 8'hC3); ew(3'd3, 8'h00); ed(2'b10, 8'hC3, 1'b0);
    end
    req = 2'b11;
    wait_done(0, lat); wait_done(1, lat); wait_done(0, lat); wait_done(1, lat);
    req = 2'b00;
    wait_idle();
    // locked burst from requester 1 while requester 0 waits
    xmask = 8'h0F;
    cs_sel = {3'd4, 3'd7}; tx = {8'h01, 8'h77};
    ew(3'd3, 8'h8C); ew(3'd1, 8'h01); ew(3'd1, 8'h02); ew(3'd1, 8'h03); ew(3'd3, 8'h00);
    ew(3'd3, 8'h8F); ew(3'd1, 8'h77); ew(3'd3, 8'h00);
    ed(2'b10, 8'h0E, 1'b0); ed(2'b10, 8'h0D, 1'b0); ed(2'b10, 8'h0C, 1'b0); ed(2'b01, 8'h78, 1'b0);
    hold = 2'b10; req = 2'b10;
    wait_gnt(1);
    req[0] = 1'b1;
    wait_done(1, lat); tx[15:8] = 8'h02;
    wait_done(1, lat); tx[15:8] = 8'h03;
    wait_done(1, lat); req[1] = 1'b0;
    tick();
    chk("lock_gnt", 16'(gnt), 16'b10);
    chk("lock_spi_cs", 16'(spi_cs), 16'd0);
    chk("lock_busy", 16'(busy), 16'd1);
    repeat (2) tick();
    chk("lock_gnt_held", 16'(gnt), 16'b10);
    hold[1] = 1'b0;
    wait_done(0, lat); req[0] = 1'b0;
    wait_idle();
    // RDY never falls: timeout keeps old rx
    lo_delay = 1000;
    cs_sel[2:0] = 3'd5; tx[7:0] = 8'h99;
    ew(3'd3, 8'h8D); ew(3'd1, 8'h99); ew(3'd3, 8'h00); ed(2'b01, 8'h78, 1'b1);
    req[0] = 1'b1;
    wait_done(0, lat); req[0] = 1'b0;
    wait_idle();
    chk("err_sticky", 16'(err), 16'd1);
    lo_delay = 2;
    cs_sel[5:3] = 3'd6; tx[15:8] = 8'h42;
    ew(3'd3, 8'h8E); ew(3'd1, 8'h42); ew(3'd3, 8'h00); ed(2'b10, 8'h4D, 1'b0);
    req[1] = 1'b1;
    wait_gnt(1);
    chk("err_cleared_on_grant", 16'(err), 16'd0);
    wait_done(1, lat); req[1] = 1'b0;
    wait_idle();
    // reset while waiting for RDY to rise
    busy_len = 50;
    cs_sel[2:0] = 3'd0; tx[7:0] = 8'h3C;
    ew(3'd3, 8'h88); ew(3'd1, 8'h3C);
    req[0] = 1'b1;
    begin
      int k;
      for (k = 0; k < 200; k++) begin
        tick();
        if (ph == 2) break;
      end
      chk("rdy_low_wait_bound", 16'(k < 200), 16'd1);
    end
    repeat (3) tick();
    rst = 1'b1; req = 2'b00;
    tick();
    chk("midrst_gnt", 16'(gnt), 16'd0);
    chk("midrst_busy", 16'(busy), 16'd0);
    chk("midrst_spi_cs", 16'(spi_cs), 16'd0);
    chk("midrst_rx", 16'(rx), 16'hFF);
    chk("midrst_err", 16'(err), 16'd0);
    rst = 1'b0; busy_len = 4;
    cs_sel[5:3] = 3'd2; tx[15:8] = 8'h6E;
    ew(3'd3, 8'h8A); ew(3'd1, 8'h6E); ew(3'd3, 8'h00); ed(2'b10, 8'h61, 1'b0);
    req[1] = 1'b1;
    wait_done(1, lat); req[1] = 1'b0;
    wait_idle();
    // slow shift: long RDY-low phase without timeout
    lo_delay = 3; busy_len = 600; xmask = 8'h5A; poll_cnt = 0;
    cs_sel[2:0] = 3'd1; tx[7:0] = 8'hE1;
    ew(3'd3, 8'h89); ew(3'd1, 8'hE1); ew(3'd3, 8'h00); ed(2'b01, 8'hBB, 1'b0);
    req[0] = 1'b1;
    wait_done(0, lat); req[0] = 1'b0;
    wait_idle();
    chk("slow_no_err", 16'(err), 16'd0);
    chk("slow_polled_long", 16'(poll_cnt >= 600), 16'd1);
    repeat (3) tick();
    chk("poll_bus_steady", 16'(poll_bad), 16'd0);
    chk("done_queue_empty", 16'(dq.size()), 16'd0);
    chk("write_queue_empty", 16'(wq.size()), 16'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
